// File: rtl/dfr_capture_ctrl_if.sv
// Sample, control and readback signals between the reservoir/AXI side and dfr_capture_ctrl.
// The master drives samples, control and the read address; the slave (capture engine) returns status and data.
interface dfr_capture_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  frame_sync;
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [ADDR_WIDTH:0]   num_samples;
  logic                  busy;
  logic                  done;
  logic                  wrapped;
  logic [ADDR_WIDTH:0]   sample_count;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output din_valid, din, frame_sync, start, stop, mode, num_samples, rd_addr,
    input  busy, done, wrapped, sample_count, wr_ptr, rd_data
  );

  modport slave (
    input  din_valid, din, frame_sync, start, stop, mode, num_samples, rd_addr,
    output busy, done, wrapped, sample_count, wr_ptr, rd_data
  );
endinterface

// File: rtl/dfr_capture_ctrl.sv
// Frame-aligned capture of reservoir node samples into a history RAM.
// Supports one-shot and continuous ring modes, with a registered read-first readback port.
module dfr_capture_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int VIRTUAL_NODES  = 10,
  parameter int NODE_CNT_WIDTH = 8
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  dfr_capture_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]         CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]         CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]         DEPTH      = CNT_ONE << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]       PTR_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]       PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]       PTR_LAST   = {ADDR_WIDTH{1'b1}};
  localparam logic [NODE_CNT_WIDTH-1:0]   NODE_ZERO  = {NODE_CNT_WIDTH{1'b0}};
  localparam logic [NODE_CNT_WIDTH-1:0]   NODE_ONE   = NODE_CNT_WIDTH'(1);
  localparam logic [NODE_CNT_WIDTH-1:0]   NODE_LAST  = NODE_CNT_WIDTH'(VIRTUAL_NODES - 1);
  // With a single node per frame the counter must stay at zero after a sync beat.
  localparam logic [NODE_CNT_WIDTH-1:0]   NODE_AFTER = (VIRTUAL_NODES == 1) ? NODE_ZERO : NODE_ONE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NODE_CNT_WIDTH-1:0] node_cnt_q, node_cnt_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wrapped_q, wrapped_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    we_s;
  logic [ADDR_WIDTH-1:0]   waddr_s;
  logic                    frame_start_s;
  logic [ADDR_WIDTH:0]     count_inc_s;

  // Next-state, counter and write-port decode.
  always_comb begin
    state_d    = state_q;
    node_cnt_d = node_cnt_q;
    mode_d     = mode_q;
    len_d      = len_q;
    wrapped_d  = wrapped_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    we_s       = 1'b0;
    waddr_s    = wr_ptr_q;

    frame_start_s = bus.din_valid && (bus.frame_sync || (node_cnt_q == NODE_ZERO));
    count_inc_s   = (count_q == DEPTH) ? DEPTH : (count_q + CNT_ONE);

    if (bus.din_valid) begin
      if (bus.frame_sync) begin
        node_cnt_d = NODE_AFTER;
      end else if (node_cnt_q == NODE_LAST) begin
        node_cnt_d = NODE_ZERO;
      end else begin
        node_cnt_d = node_cnt_q + NODE_ONE;
      end
    end else begin
      node_cnt_d = node_cnt_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_ARMED;
          mode_d    = bus.mode;
          len_d     = (bus.num_samples == CNT_ZERO) ? DEPTH : bus.num_samples;
          wrapped_d = 1'b0;
          count_d   = CNT_ZERO;
          wr_ptr_d  = PTR_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (frame_start_s) begin
          we_s     = 1'b1;
          waddr_s  = PTR_ZERO;
          wr_ptr_d = PTR_ONE;
          count_d  = CNT_ONE;
          if (!mode_q && (len_q == CNT_ONE)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (bus.din_valid) begin
          we_s     = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_inc_s;
          if (mode_q && (wr_ptr_q == PTR_LAST)) begin
            wrapped_d = 1'b1;
          end else begin
            wrapped_d = wrapped_q;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        // A stop still lets a same-cycle valid beat land before finishing.
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (!mode_q && bus.din_valid && (count_inc_s == len_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // Control state and registered status/readback outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      node_cnt_q <= NODE_ZERO;
      mode_q     <= 1'b0;
      len_q      <= CNT_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      count_q    <= CNT_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      node_cnt_q <= node_cnt_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrapped_q  <= wrapped_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_data_q  <= mem[bus.rd_addr];
    end
  end

  // History RAM write port; contents deliberately survive reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (we_s) begin
      mem[waddr_s] <= bus.din;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wrapped      = wrapped_q;
  assign bus.sample_count = count_q;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_data      = rd_data_q;
endmodule

// File: tb/tb_dfr_capture_ctrl.sv
// Directed plus randomized bench for dfr_capture_ctrl, checked against a capture-session model.
module tb_dfr_capture_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int VN = 10;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfr_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dfr_capture_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VIRTUAL_NODES(VN), .NODE_CNT_WIDTH(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Session model: phase 0 idle, 1 waiting for frame, 2 capturing, 3 finished.
  int          m_phase, m_len, m_n, m_pos;
  bit          m_cont;
  logic [31:0] m_mem [D];
  bit          m_known [D];
  logic [31:0] m_rd;
  bit          m_rd_known;

  logic [31:0] s[$];
  logic [31:0] s2_5, t3x, s5_1, stop_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_pos = 0; m_cont = 1'b0; m_len = 0;
    m_rd = 32'd0; m_rd_known = 1'b1;
  endtask

  task automatic mwrite(input logic [31:0] d);
    m_mem[m_n % D] = d;
    m_known[m_n % D] = 1'b1;
    m_n++;
  endtask

  task automatic model_step();
    bit node0;
    int cnt;
    if (m_known[bus.rd_addr]) begin
      m_rd = m_mem[bus.rd_addr];
      m_rd_known = 1'b1;
    end else begin
      m_rd_known = 1'b0;
    end
    node0 = bus.din_valid && (bus.frame_sync || m_pos == 0);
    if (bus.din_valid) m_pos = bus.frame_sync ? (1 % VN) : ((m_pos + 1) % VN);
    case (m_phase)
      0, 3: if (bus.start) begin
        m_phase = 1; m_cont = bus.mode;
        m_len = (bus.num_samples == 0) ? D : int'(bus.num_samples);
        m_n = 0;
      end
      1: if (bus.stop) m_phase = 0;
         else if (node0) begin
           mwrite(bus.din);
           m_phase = (!m_cont && m_len == 1) ? 3 : 2;
         end
      2: begin
        if (bus.din_valid) mwrite(bus.din);
        cnt = (m_n > D) ? D : m_n;
        if (bus.stop || (!m_cont && bus.din_valid && cnt == m_len)) m_phase = 3;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("busy", bus.busy, (m_phase == 1 || m_phase == 2));
    check("done", bus.done, m_phase == 3);
    check("wrapped", bus.wrapped, m_cont && m_n >= D);
    check("sample_count", bus.sample_count, (m_n > D) ? D : m_n);
    check("wr_ptr", bus.wr_ptr, m_n % D);
    if (m_rd_known) check("rd_data", bus.rd_data, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.din_valid = 1'b0; bus.frame_sync = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic do_start(input bit md, input int ns);
    idle(); bus.start = 1'b1; bus.mode = md; bus.num_samples = (AW+1)'(ns);
    tick(); idle();
  endtask

  task automatic beat(input bit fs, input logic [31:0] d);
    bus.din_valid = 1'b1; bus.frame_sync = fs; bus.din = d;
    tick();
  endtask

  task automatic readback(input string tag, input int a, input logic [31:0] exp);
    idle(); bus.rd_addr = AW'(a);
    tick();
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    idle(); bus.mode = 1'b0; bus.num_samples = '0; bus.din = '0; bus.rd_addr = '0;
    for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; check_outputs();
    rst_n = 1'b1;

    // 1: one-shot of 5 started with node counter at 3
    beat(1'b1, $urandom); beat(1'b0, $urandom); beat(1'b0, $urandom);
    do_start(1'b0, 5);
    for (int i = 0; i < 12; i++) begin
      beat(1'b0, 32'(100 + i));
      if (i == 10) check("t1_done_early", bus.done, 1'b0);
      if (i == 11) check("t1_done", bus.done, 1'b1);
    end
    idle(); bus.mode = 1'b1; bus.num_samples = 5'd9; tick();
    check("t1_count", bus.sample_count, 5);
    check("t1_wr_ptr", bus.wr_ptr, 5);
    for (int a = 0; a < 5; a++) readback("t1_mem", a, 32'(107 + a));

    // 2: continuous, 20 beats then stop
    do_start(1'b1, $urandom_range(0, 31));
    s.delete();
    for (int i = 0; i < 20; i++) begin
      s.push_back($urandom);
      beat(i == 0, s[i]);
    end
    idle(); bus.stop = 1'b1; tick(); idle();
    check("t2_wrapped", bus.wrapped, 1'b1);
    check("t2_count", bus.sample_count, 16);
    check("t2_wr_ptr", bus.wr_ptr, 4);
    check("t2_done", bus.done, 1'b1);
    for (int a = 0; a < D; a++) readback("t2_mem", a, (a < 4) ? s[16 + a] : s[a]);
    s2_5 = s[5];

    // 3: valid toggling during one-shot of 3
    do_start(1'b0, 3);
    for (int i = 0; i < 8; i++) begin
      bus.din_valid = (i % 2 == 0); bus.frame_sync = (i == 0); bus.din = $urandom;
      tick();
      if (i == 3) check("t3_done_early", bus.done, 1'b0);
      if (i == 4) check("t3_done", bus.done, 1'b1);
    end
    // node counter now at 4: six non-sync beats pass before node 0
    do_start(1'b0, 1);
    for (int i = 0; i < 6; i++) beat(1'b0, $urandom);
    check("t3_wait_busy", bus.busy, 1'b1);
    check("t3_wait_count", bus.sample_count, 0);
    t3x = $urandom;
    beat(1'b0, t3x);
    idle(); tick();
    check("t3_len1_done", bus.done, 1'b1);
    check("t3_len1_count", bus.sample_count, 1);

    // 4: stop in ARMED beats a frame boundary; stop with valid in CAPTURE
    do_start(1'b0, 4);
    bus.stop = 1'b1; bus.din_valid = 1'b1; bus.frame_sync = 1'b1; bus.din = $urandom;
    tick(); idle(); tick();
    check("t4_idle_busy", bus.busy, 1'b0);
    check("t4_idle_done", bus.done, 1'b0);
    readback("t4_mem0", 0, t3x);
    do_start(1'b0, 8);
    beat(1'b1, $urandom); beat(1'b0, $urandom);
    stop_val = $urandom;
    bus.stop = 1'b1; beat(1'b0, stop_val); idle();
    check("t4_stop_done", bus.done, 1'b1);
    check("t4_stop_count", bus.sample_count, 3);
    readback("t4_stop_mem", 2, stop_val);

    // 5: reset mid-capture
    do_start(1'b1, 0);
    s.delete();
    for (int i = 0; i < 4; i++) begin
      s.push_back($urandom);
      beat(i == 0, s[i]);
    end
    s5_1 = s[1];
    #2 rst_n = 1'b0;
    #1; model_reset(); check_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) beat(1'b1, $urandom);
    check("t5_count", bus.sample_count, 0);
    readback("t5_retained", 1, s5_1);

    // 6: num_samples 0 captures the full depth, read-first on the written address
    do_start(1'b0, 0);
    s.delete();
    for (int i = 0; i < 20; i++) begin
      s.push_back($urandom);
      bus.rd_addr = AW'(i);
      beat(i == 0, s[i]);
      if (i == 5) check("t6_read_first", bus.rd_data, s2_5);
    end
    idle(); tick();
    check("t6_done", bus.done, 1'b1);
    check("t6_count", bus.sample_count, 16);
    check("t6_wrapped", bus.wrapped, 1'b0);
    readback("t6_addr7", 7, s[7]);

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      bus.din_valid   = ($urandom_range(0, 3) != 0);
      bus.frame_sync  = ($urandom_range(0, 15) == 0);
      bus.start       = ($urandom_range(0, 19) == 0);
      bus.stop        = ($urandom_range(0, 29) == 0);
      bus.mode        = 1'($urandom_range(0, 1));
      bus.num_samples = (AW+1)'($urandom_range(0, 20));
      bus.din         = $urandom;
      bus.rd_addr     = AW'($urandom_range(0, D - 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
